// File: rtl/clb_config_loader.sv
// rtl/clb_config_loader.sv - serial CLB configuration loader with shadow register and atomic commit
// Optional even-parity frame bit is compiled in with macro CLB_CFG_PARITY_EN.
module clb_config_loader #(
    parameter bit CLEAR_ON_START = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic        cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic [5:0]  input_configuration_word,
    output logic [15:0] lut_configuration_word,
    output logic [2:0]  flip_flop_configuration_word,
    output logic [1:0]  output_configuration_word,
    output logic        cfg_done,
    output logic        cfg_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  bit_cnt;
    logic [26:0] shadow;
    logic        accept;
    logic        parity_ok;

`ifdef CLB_CFG_PARITY_EN
    localparam logic [4:0] LAST_BIT = 5'd27;
    logic parity_bit;
    // Even parity: data bits plus the parity bit must XOR to zero.
    assign parity_ok = ~(^shadow ^ parity_bit);
`else
    localparam logic [4:0] LAST_BIT = 5'd26;
    assign parity_ok = 1'b1;
`endif

    assign cfg_ready = (state == SHIFT);
    assign accept    = (state == SHIFT) && cfg_valid;

    always_comb begin
        state_next = state;
        if (cfg_start) begin
            state_next = SHIFT;
        end else begin
            case (state)
                SHIFT: if (accept && (bit_cnt == LAST_BIT)) state_next = CHECK;
                CHECK: state_next = parity_ok ? IDLE : ERROR;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt                      <= 5'd0;
            shadow                       <= 27'd0;
            input_configuration_word     <= 6'd0;
            lut_configuration_word       <= 16'd0;
            flip_flop_configuration_word <= 3'd0;
            output_configuration_word    <= 2'd0;
            cfg_done                     <= 1'b0;
            cfg_error                    <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
            parity_bit                   <= 1'b0;
`endif
        end else begin
            cfg_done <= 1'b0;
            if (cfg_start) begin
                // A start in any state discards the frame in progress.
                bit_cnt   <= 5'd0;
                shadow    <= 27'd0;
                cfg_error <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
                parity_bit <= 1'b0;
`endif
                if (CLEAR_ON_START) begin
                    input_configuration_word     <= 6'd0;
                    lut_configuration_word       <= 16'd0;
                    flip_flop_configuration_word <= 3'd0;
                    output_configuration_word    <= 2'd0;
                end
            end else if (accept) begin
`ifdef CLB_CFG_PARITY_EN
                if (bit_cnt == LAST_BIT) begin
                    parity_bit <= cfg_data;
                end else begin
                    shadow <= shadow | (27'(cfg_data) << bit_cnt);
                end
`else
                shadow <= shadow | (27'(cfg_data) << bit_cnt);
`endif
                bit_cnt <= bit_cnt + 5'd1;
            end else if (state == CHECK) begin
                if (parity_ok) begin
                    input_configuration_word     <= shadow[5:0];
                    lut_configuration_word       <= shadow[21:6];
                    flip_flop_configuration_word <= shadow[24:22];
                    output_configuration_word    <= shadow[26:25];
                    cfg_done                     <= 1'b1;
                end else begin
                    cfg_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clb_config_loader.sv
// tb/tb_clb_config_loader.sv - directed self-checking bench for clb_config_loader
module tb_clb_config_loader;

`ifdef CLB_CFG_PARITY_EN
    localparam int NB = 28;
`else
    localparam int NB = 27;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_data = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, cfg_done, cfg_error;
    logic [5:0]  in_w;
    logic [15:0] lut_w;
    logic [2:0]  ff_w;
    logic [1:0]  out_w;
    logic        c_ready, c_done, c_error;
    logic [5:0]  c_in_w;
    logic [15:0] c_lut_w;
    logic [2:0]  c_ff_w;
    logic [1:0]  c_out_w;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [26:0] FRAME_GOOD  = {2'b10, 3'b101, 16'hF00F, 6'h2A};
    localparam logic [26:0] FRAME_STALL = {2'b01, 3'b011, 16'hA5C3, 6'h15};
    localparam logic [26:0] FRAME_JUNK  = {2'b11, 3'b111, 16'hFFFF, 6'h3F};
    localparam logic [26:0] FRAME_ABORT = {2'b11, 3'b010, 16'h1234, 6'h3F};

    clb_config_loader #(.CLEAR_ON_START(1'b0)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .input_configuration_word(in_w), .lut_configuration_word(lut_w),
        .flip_flop_configuration_word(ff_w), .output_configuration_word(out_w),
        .cfg_done(cfg_done), .cfg_error(cfg_error)
    );

    clb_config_loader #(.CLEAR_ON_START(1'b1)) dut_c (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(c_ready),
        .input_configuration_word(c_in_w), .lut_configuration_word(c_lut_w),
        .flip_flop_configuration_word(c_ff_w), .output_configuration_word(c_out_w),
        .cfg_done(c_done), .cfg_error(c_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Sends bits [first, last) of the frame; bit 27 is the even parity bit, optionally inverted.
    task automatic send_bits(input logic [26:0] f, input int first, input int last, input bit bad_par);
        logic [27:0] fr;
        fr = {(^f) ^ bad_par, f};
        for (int i = first; i < last; i++) begin
            cfg_data  = fr[i];
            cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    task automatic test_reset_initial();
        total_cnt++;
        if ({cfg_ready, cfg_done, cfg_error, out_w, ff_w, lut_w, in_w} !== 30'd0)
            $display("FAIL reset_outputs got %h want 0", {cfg_ready, cfg_done, cfg_error, out_w, ff_w, lut_w, in_w});
        else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL idle_ready got %b want 0", cfg_ready);
        else pass_cnt++;
    endtask

    task automatic test_good_load();
        pulse_start();
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL shift_ready got %b want 1", cfg_ready);
        else pass_cnt++;
        send_bits(FRAME_GOOD, 0, NB, 1'b0);
        total_cnt++;
        if (cfg_done !== 1'b0 || cfg_ready !== 1'b0)
            $display("FAIL good_check_cycle got done=%b ready=%b want 0 0", cfg_done, cfg_ready);
        else pass_cnt++;
        total_cnt++;
        if ({out_w, ff_w, lut_w, in_w} !== 27'd0)
            $display("FAIL good_no_early_commit got %h want 0", {out_w, ff_w, lut_w, in_w});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (cfg_done !== 1'b1) $display("FAIL good_done got %b want 1", cfg_done);
        else pass_cnt++;
        total_cnt++;
        if (in_w !== 6'h2A || lut_w !== 16'hF00F || ff_w !== 3'b101 || out_w !== 2'b10)
            $display("FAIL good_words got %h %h %b %b want 2a f00f 101 10", in_w, lut_w, ff_w, out_w);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (cfg_done !== 1'b0 || cfg_error !== 1'b0)
            $display("FAIL good_done_width got done=%b err=%b want 0 0", cfg_done, cfg_error);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        pulse_start();
        send_bits(FRAME_STALL, 0, 10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cfg_data = ~cfg_data;
            tick();
        end
        total_cnt++;
        if (cfg_ready !== 1'b1 || cfg_done !== 1'b0)
            $display("FAIL stall_state got ready=%b done=%b want 1 0", cfg_ready, cfg_done);
        else pass_cnt++;
        total_cnt++;
        if ({out_w, ff_w, lut_w, in_w} !== FRAME_GOOD)
            $display("FAIL stall_hold got %h want %h", {out_w, ff_w, lut_w, in_w}, FRAME_GOOD);
        else pass_cnt++;
        send_bits(FRAME_STALL, 10, NB, 1'b0);
        tick();
        total_cnt++;
        if (cfg_done !== 1'b1 || {out_w, ff_w, lut_w, in_w} !== FRAME_STALL)
            $display("FAIL stall_commit got done=%b words=%h want 1 %h", cfg_done, {out_w, ff_w, lut_w, in_w}, FRAME_STALL);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_bits(FRAME_GOOD, 0, 5, 1'b0);
        cfg_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({cfg_ready, cfg_done, cfg_error, out_w, ff_w, lut_w, in_w} !== 30'd0)
            $display("FAIL reset_mid got %h want 0", {cfg_ready, cfg_done, cfg_error, out_w, ff_w, lut_w, in_w});
        else pass_cnt++;
        tick();
        reset = 1'b1;
        send_bits(FRAME_GOOD, 5, NB, 1'b0);
        tick();
        tick();
        total_cnt++;
        if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || {out_w, ff_w, lut_w, in_w} !== 27'd0)
            $display("FAIL reset_no_resume got ready=%b done=%b words=%h want 0 0 0", cfg_ready, cfg_done, {out_w, ff_w, lut_w, in_w});
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int done_seen;
        pulse_start();
        send_bits(FRAME_JUNK, 0, 12, 1'b0);
        pulse_start();
        send_bits(FRAME_ABORT, 0, NB, 1'b0);
        total_cnt++;
        if (cfg_done !== 1'b0 || {out_w, ff_w, lut_w, in_w} !== 27'd0)
            $display("FAIL abort_no_first got done=%b words=%h want 0 0", cfg_done, {out_w, ff_w, lut_w, in_w});
        else pass_cnt++;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cfg_done === 1'b1) done_seen++;
        end
        total_cnt++;
        if (done_seen != 1 || {out_w, ff_w, lut_w, in_w} !== FRAME_ABORT)
            $display("FAIL abort_second got done_count=%0d words=%h want 1 %h", done_seen, {out_w, ff_w, lut_w, in_w}, FRAME_ABORT);
        else pass_cnt++;
    endtask

`ifdef CLB_CFG_PARITY_EN
    task automatic test_parity_error();
        pulse_start();
        send_bits(FRAME_GOOD, 0, NB, 1'b1);
        tick();
        total_cnt++;
        if (cfg_error !== 1'b1 || cfg_done !== 1'b0)
            $display("FAIL parity_error got err=%b done=%b want 1 0", cfg_error, cfg_done);
        else pass_cnt++;
        total_cnt++;
        if ({out_w, ff_w, lut_w, in_w} !== FRAME_ABORT)
            $display("FAIL parity_retain got %h want %h", {out_w, ff_w, lut_w, in_w}, FRAME_ABORT);
        else pass_cnt++;
        pulse_start();
        total_cnt++;
        if (cfg_error !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL parity_clear got err=%b ready=%b want 0 1", cfg_error, cfg_ready);
        else pass_cnt++;
        send_bits(FRAME_ABORT, 0, NB, 1'b0);
        tick();
        tick();
    endtask
`else
    task automatic test_no_error();
        total_cnt++;
        if (cfg_error !== 1'b0) $display("FAIL no_parity_error got %b want 0", cfg_error);
        else pass_cnt++;
    endtask
`endif

    task automatic test_clear_on_start();
        total_cnt++;
        if ({c_out_w, c_ff_w, c_lut_w, c_in_w} !== FRAME_ABORT)
            $display("FAIL clear_pre got %h want %h", {c_out_w, c_ff_w, c_lut_w, c_in_w}, FRAME_ABORT);
        else pass_cnt++;
        pulse_start();
        total_cnt++;
        if ({c_out_w, c_ff_w, c_lut_w, c_in_w} !== 27'd0 || c_ready !== 1'b1)
            $display("FAIL clear_words got %h ready=%b want 0 1", {c_out_w, c_ff_w, c_lut_w, c_in_w}, c_ready);
        else pass_cnt++;
        total_cnt++;
        if ({out_w, ff_w, lut_w, in_w} !== FRAME_ABORT)
            $display("FAIL clear_default_hold got %h want %h", {out_w, ff_w, lut_w, in_w}, FRAME_ABORT);
        else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset_initial();
        test_good_load();
        test_stall();
        test_reset_mid();
        test_abort();
`ifdef CLB_CFG_PARITY_EN
        test_parity_error();
`else
        test_no_error();
`endif
        test_clear_on_start();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
